divider_arbiter: RTL
====================

// Module: divider_arbiter
// PURPOSE
//  Shares one iterative divider between NREQ requesters using round-robin arbitration.
//  Issues one division at a time and captures q/r/dbz into a single response register.
//  Returns the response with the requester id under valid/ready backpressure.
//  Sits between client blocks and the divider; the divider's out_valid pulse cannot stall.
// PARAMETERS
//  WIDTH    4             operand/result width, must match the divider
//  NREQ     4             number of requesters, >=2
//  IDW      $clog2(NREQ)  response id width
//  TIMEOUT  2*WIDTH+4     max BUSY cycles before an error response is returned
// PORTS
//  clk            in   1         clock, all state on rising edge
//  rst            in   1         asynchronous, active-high reset
//  req_valid      in   NREQ      per-requester request valid
//  req_ready      out  NREQ      per-requester accept, one-hot or zero
//  req_x          in   NREQ*W    dividends; requester k at [k*W +: W]
//  req_y          in   NREQ*W    divisors; same packing as req_x
//  rsp_valid      out  1         response valid
//  rsp_ready      in   1         response accept
//  rsp_id         out  IDW       index of the requester that owns the response
//  rsp_q, rsp_r   out  W         quotient, remainder
//  rsp_dbz        out  1         divide by zero
//  rsp_err        out  1         watchdog timeout; q/r invalid
//  div_in_valid   out  1         to divider in_valid
//  div_in_ready   in   1         from divider in_ready
//  div_x, div_y   out  W         to divider x, y
//  div_out_valid  in   1         divider completion pulse, 1 cycle
//  div_q, div_r   in   W         divider results
//  div_dbz        in   1         divider dbz, combinational in the accept cycle
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, rsp_valid=0, rsp_*=0, req_ready=0, div_in_valid=0, wdog=0.
//  Reset mid-operation: abandons the operation; a later div_out_valid is ignored in IDLE.
//  FSM states: IDLE, BUSY, RESP.
//  IDLE:
//   - Winner = first k with req_valid[k], searching ptr, ptr+1, ... mod NREQ.
//   - div_in_valid = |req_valid. div_x/div_y = winner operands, combinational.
//   - req_ready[winner] = div_in_ready; all other req_ready bits are 0.
//   - On handshake (div_in_valid & div_in_ready), ptr <= (winner+1) mod NREQ and the winner id is latched.
//   - If div_dbz is high in the handshake cycle: load rsp (dbz=1, q={W{1}}, r=x, err=0) and go to RESP.
//   - Otherwise go to BUSY and clear wdog.
//  BUSY:
//   - div_in_valid=0, req_ready=0, wdog increments each cycle.
//   - On div_out_valid: capture div_q/div_r (dbz=0, err=0), go to RESP. rsp_valid rises the next cycle.
//   - If wdog reaches TIMEOUT-1 without div_out_valid: load err=1, q=r=0, go to RESP.
//   - Nominal: accept at cycle 0, div_out_valid at cycle WIDTH, rsp_valid at cycle WIDTH+1.
//  RESP:
//   - rsp_valid=1; rsp_* are stable until handshake.
//   - No new issue while in RESP, because the response register is single-entry.
//   - On rsp_ready, go to IDLE; the next grant is possible in the following cycle.
//  Arbitration:
//   - A requester that drops req_valid before grant loses its turn and no state is kept.
//   - No starvation: a continuously valid requester is granted within NREQ grants.
//  Simultaneous events:
//   - div_out_valid in IDLE or RESP is ignored.
//   - rsp_ready while rsp_valid=0 is ignored.
//  Widths:
//   - div results pass through unmodified; no arithmetic in this block beyond ptr and wdog.
//   - ptr wraps NREQ-1 -> 0; wdog width is $clog2(TIMEOUT+1).
// TESTING
//  1. Single request: req 2 (x=13, y=4), rsp_ready=1 -> rsp id=2, q=3, r=1 at cycle WIDTH+1, dbz=0.
//  2. Fairness: all 4 requests held valid, ptr=0 -> grant order 0,1,2,3,0; each id is returned once per cycle of grants.
//  3. Divide by zero: req 1 (x=9, y=0) -> RESP the next cycle with dbz=1, q=4'hF, r=9; no BUSY.
//  4. Backpressure: rsp_ready=0 for 20 cycles with req 0,3 pending -> rsp is stable and req_ready=0 throughout; req 3 issues after the release.
//  5. Timeout: div_out_valid tied low -> err=1 after TIMEOUT BUSY cycles, then IDLE.
//  6. Reset mid-op: rst in BUSY, stray div_out_valid after release -> rsp_valid stays 0 and ptr=0.

Source files
------------

// File: rtl/divider_arbiter.sv
// Round-robin front end that shares one iterative divider among NREQ clients and
// returns each result, tagged with its requester id, through a single-entry response register.
module divider_arbiter #(
    parameter int WIDTH   = 4,
    parameter int NREQ    = 4,
    parameter int IDW     = $clog2(NREQ),
    parameter int TIMEOUT = 2 * WIDTH + 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_x,
    input  logic [NREQ*WIDTH-1:0] req_y,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_q,
    output logic [WIDTH-1:0]      rsp_r,
    output logic                  rsp_dbz,
    output logic                  rsp_err,
    output logic                  div_in_valid,
    input  logic                  div_in_ready,
    output logic [WIDTH-1:0]      div_x,
    output logic [WIDTH-1:0]      div_y,
    input  logic                  div_out_valid,
    input  logic [WIDTH-1:0]      div_q,
    input  logic [WIDTH-1:0]      div_r,
    input  logic                  div_dbz,
    output logic [1:0]            dbg_state_o,
    output logic [IDW-1:0]        dbg_ptr_o
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Handshakes: a transfer happens on any rising edge where valid and ready are both high.
    // req_ready is at most one-hot and only asserted in IDLE; rsp_* hold steady while rsp_valid waits.
    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WDW-1:0]   wdog_q, wdog_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dbz_q, dbz_d;
    logic             err_q, err_d;

    logic [IDW-1:0]   win;
    logic             win_found;

    // Search starts at ptr and wraps; int arithmetic keeps non-power-of-two NREQ correct.
    always_comb begin
        win       = ptr_q;
        win_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (int'(ptr_q) + i) % NREQ;
            if (!win_found && req_valid[k]) begin
                win       = IDW'(k);
                win_found = 1'b1;
            end
        end
    end

    assign div_x = req_x[int'(win)*WIDTH +: WIDTH];
    assign div_y = req_y[int'(win)*WIDTH +: WIDTH];

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        wdog_d       = wdog_q;
        q_d          = q_q;
        r_d          = r_q;
        dbz_d        = dbz_q;
        err_d        = err_q;
        req_ready    = '0;
        div_in_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                div_in_valid = win_found;
                if (win_found) req_ready[win] = div_in_ready;
                if (win_found && div_in_ready) begin
                    id_d  = win;
                    ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
                    if (div_dbz) begin
                        // The divider never runs for a zero divisor, so answer directly.
                        q_d     = '1;
                        r_d     = div_x;
                        dbz_d   = 1'b1;
                        err_d   = 1'b0;
                        state_d = S_RESP;
                    end else begin
                        wdog_d  = '0;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                wdog_d = wdog_q + 1'b1;
                if (div_out_valid) begin
                    q_d     = div_q;
                    r_d     = div_r;
                    dbz_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                    q_d     = '0;
                    r_d     = '0;
                    dbz_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            wdog_q  <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            wdog_q  <= wdog_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_id      = id_q;
    assign rsp_q       = q_q;
    assign rsp_r       = r_q;
    assign rsp_dbz     = dbz_q;
    assign rsp_err     = err_q;
    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;

endmodule
